// File: rtl/sliced_logic_unit.sv
// sliced_logic_unit: bitwise AND/OR/XOR/NOR evaluated one SLICE-bit lane per clock, LSB lane first
// Ports: clk, reset (async, active-high); in_valid/in_ready, op, a, b accept an operation;
//        out_valid/out_ready hand off result and zero; busy is high while lanes are being computed.
module sliced_logic_unit #(
   parameter int WIDTH = 32,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d, full;
   logic [1:0] op_q, op_d;
   logic zero_q, zero_d, accept, last;
   assign full = op_q == 2'b00 ? a_q & b_q : op_q == 2'b01 ? a_q | b_q : op_q == 2'b10 ? a_q ^ b_q : ~(a_q | b_q);
   // HOLD accepts in the same cycle the result is consumed, allowing back-to-back operations
   assign in_ready = state_q == IDLE || (state_q == HOLD && out_ready);
   assign accept = in_valid && in_ready;
   assign last = cnt_q == CW'(NSLICE - 1);
   assign out_valid = state_q == HOLD;
   assign busy = state_q == RUN;
   assign result = result_q;
   assign zero = zero_q;
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      a_d = a_q;
      b_d = b_q;
      op_d = op_q;
      result_d = result_q;
      if (accept) begin
         state_d = RUN;
         cnt_d = '0;
         a_d = a;
         b_d = b;
         op_d = op;
         result_d = '0;
      end else if (state_q == RUN) begin
         result_d[int'(cnt_q)*SLICE +: SLICE] = full[int'(cnt_q)*SLICE +: SLICE];
         cnt_d = last ? '0 : cnt_q + 1'b1;
         state_d = last ? HOLD : RUN;
      end else if (state_q == HOLD && out_ready) begin
         state_d = IDLE;
      end
      // result is unchanged while staying in HOLD, so this both sets zero on entry and holds it
      zero_d = state_d == HOLD && result_d == '0;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
         a_q <= '0;
         b_q <= '0;
         op_q <= '0;
         result_q <= '0;
         zero_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         a_q <= a_d;
         b_q <= b_d;
         op_q <= op_d;
         result_q <= result_d;
         zero_q <= zero_d;
      end
   end
endmodule

// File: tb/tb_sliced_logic_unit.sv
// tb_sliced_logic_unit: scoreboard bench for sliced_logic_unit at 32/4, 8/8 and 64/4
module tb_sliced_logic_unit;
  logic clk = 1'b0, reset;
  always #5 clk = ~clk;
  logic in_valid, out_ready, in_ready, out_valid, zero, busy;
  logic [1:0] op;
  logic [31:0] a, b, result;
  logic v8, or8, rdy8, ov8, z8, busy8;
  logic [1:0] op8;
  logic [7:0] a8, b8, res8;
  logic v64, or64, rdy64, ov64, z64, busy64;
  logic [1:0] op64;
  logic [63:0] a64, b64, res64;
  int errors = 0, checks = 0;
  logic [32:0] sbq[$];
  logic [8:0] sbq8[$];
  logic [64:0] sbq64[$];

  sliced_logic_unit #(.WIDTH(32), .SLICE(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero), .busy(busy));
  sliced_logic_unit #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8), .op(op8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .result(res8), .zero(z8), .busy(busy8));
  sliced_logic_unit #(.WIDTH(64), .SLICE(4)) dut64 (
    .clk(clk), .reset(reset), .in_valid(v64), .in_ready(rdy64), .op(op64), .a(a64), .b(b64),
    .out_valid(ov64), .out_ready(or64), .result(res64), .zero(z64), .busy(busy64));

  function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
    return o == 2'b00 ? x & y : o == 2'b01 ? x | y : o == 2'b10 ? x ^ y : ~(x | y);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] t;
    t = model(o, {32'h0, x}, {32'h0, y});
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    sbq.push_back({t[31:0] == 32'h0, t[31:0]});
    tick();
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 2'($urandom);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL consume: out_valid=%b in_ready=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 2'b00; a = '0; b = '0;
    v8 = 0; or8 = 0; op8 = 0; a8 = 0; b8 = 0;
    v64 = 0; or64 = 0; op64 = 0; a64 = 0; b64 = 0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: ov=%b busy=%b result=%h zero=%b, want 0 0 0 0", out_valid, busy, result, zero);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b ov=%b busy=%b result=%h zero=%b, want 1 0 0 0 0",
               in_ready, out_valid, busy, result, zero);
    end
  endtask

  task automatic test_or();
    int n;
    logic [32:0] e;
    issue(2'b01, 32'h0000_F0F0, 32'h0F0F_0000);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL run_flags: busy=%b in_ready=%b ov=%b zero=%b, want 1 0 0 0", busy, in_ready, out_valid, zero);
    end
    wait_out(n);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL or_latency: got %0d cycles, want 8", n);
    end
    e = sbq.pop_front();
    checks++;
    if ({zero, result} !== e) begin
      errors++;
      $display("FAIL or_result: got %b/%h, want %b/%h", zero, result, e[32], e[31:0]);
    end
    consume();
  endtask

  task automatic test_ops();
    logic [1:0] ops[3] = '{2'b00, 2'b11, 2'b10};
    int n;
    logic [32:0] e;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 32'hAAAA_AAAA, 32'h5555_5555);
      wait_out(n);
      checks++;
      if (n !== 8) begin
        errors++;
        $display("FAIL ops_latency[%0d]: got %0d, want 8", i, n);
      end
      e = sbq.pop_front();
      checks++;
      if ({zero, result} !== e) begin
        errors++;
        $display("FAIL ops_result[%0d]: got %b/%h, want %b/%h", i, zero, result, e[32], e[31:0]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [32:0] e;
    logic [31:0] hold;
    logic [63:0] t;
    issue(2'b10, 32'hDEAD_BEEF, 32'h0123_4567);
    wait_out(n);
    e = sbq.pop_front();
    checks++;
    if ({zero, result} !== e) begin
      errors++;
      $display("FAIL bp_first: got %b/%h, want %b/%h", zero, result, e[32], e[31:0]);
    end
    hold = result;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (result !== hold || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall[%0d]: result=%h ov=%b in_ready=%b, want %h 1 0", i, result, out_valid, in_ready, hold);
      end
    end
    op = 2'b00; a = 32'hFFFF_0000; b = 32'h0F0F_0F0F;
    t = model(op, {32'h0, a}, {32'h0, b});
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: in_ready=%b, want 1", in_ready);
    end
    sbq.push_back({t[31:0] == 32'h0, t[31:0]});
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: ov=%b busy=%b, want 0 1", out_valid, busy);
    end
    wait_out(n);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL b2b_latency: got %0d, want 8", n);
    end
    e = sbq.pop_front();
    checks++;
    if ({zero, result} !== e) begin
      errors++;
      $display("FAIL b2b_result: got %b/%h, want %b/%h", zero, result, e[32], e[31:0]);
    end
    consume();
  endtask

  task automatic test_ignore();
    int n;
    logic [32:0] e;
    issue(2'b10, 32'h1234_5678, 32'h0F0F_0F0F);
    in_valid = 1'b1;
    a = 32'hFFFF_0000; b = 32'h0; op = 2'b01;
    tick();
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ign_ready: in_ready=%b busy=%b, want 0 1", in_ready, busy);
    end
    tick();
    in_valid = 1'b0;
    wait_out(n);
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL ign_latency: got %0d, want 6", n);
    end
    e = sbq.pop_front();
    checks++;
    if ({zero, result} !== e) begin
      errors++;
      $display("FAIL ign_result: got %b/%h, want %b/%h", zero, result, e[32], e[31:0]);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int n;
    logic [32:0] e;
    issue(2'b01, 32'hFFFF_FFFF, 32'h0);
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    void'(sbq.pop_back());
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: ov=%b busy=%b result=%h zero=%b, want 0 0 0 0", out_valid, busy, result, zero);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: in_ready=%b busy=%b ov=%b, want 1 0 0", in_ready, busy, out_valid);
    end
    tick();
    issue(2'b11, 32'h0F00_00F0, 32'h0000_0F00);
    wait_out(n);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL mid_latency: got %0d, want 8", n);
    end
    e = sbq.pop_front();
    checks++;
    if ({zero, result} !== e) begin
      errors++;
      $display("FAIL mid_result: got %b/%h, want %b/%h", zero, result, e[32], e[31:0]);
    end
    consume();
  endtask

  task automatic test_param8();
    int n;
    logic [63:0] t;
    logic [8:0] e;
    for (int i = 0; i < 10; i++) begin
      op8 = 2'($urandom); a8 = 8'($urandom); b8 = i == 3 ? ~a8 : 8'($urandom);
      t = model(op8, {56'h0, a8}, {56'h0, b8});
      checks++;
      if (rdy8 !== 1'b1) begin
        errors++;
        $display("FAIL p8_ready[%0d]: got %b, want 1", i, rdy8);
      end
      v8 = 1'b1;
      sbq8.push_back({t[7:0] == 8'h0, t[7:0]});
      tick();
      v8 = 1'b0;
      n = 0;
      while (!ov8 && n < 50) begin tick(); n++; end
      checks++;
      if (n !== 1) begin
        errors++;
        $display("FAIL p8_latency[%0d]: got %0d, want 1", i, n);
      end
      e = sbq8.pop_front();
      checks++;
      if ({z8, res8} !== e) begin
        errors++;
        $display("FAIL p8_result[%0d]: got %b/%h, want %b/%h", i, z8, res8, e[8], e[7:0]);
      end
      or8 = 1'b1;
      tick();
      or8 = 1'b0;
    end
  endtask

  task automatic test_param64();
    int n;
    logic [63:0] t;
    logic [64:0] e;
    for (int i = 0; i < 8; i++) begin
      op64 = 2'($urandom); a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      if (i == 2) begin op64 = 2'b00; b64 = ~a64; end
      t = model(op64, a64, b64);
      checks++;
      if (rdy64 !== 1'b1) begin
        errors++;
        $display("FAIL p64_ready[%0d]: got %b, want 1", i, rdy64);
      end
      v64 = 1'b1;
      sbq64.push_back({t == 64'h0, t});
      tick();
      v64 = 1'b0;
      n = 0;
      while (!ov64 && n < 100) begin tick(); n++; end
      checks++;
      if (n !== 16) begin
        errors++;
        $display("FAIL p64_latency[%0d]: got %0d, want 16", i, n);
      end
      e = sbq64.pop_front();
      checks++;
      if ({z64, res64} !== e) begin
        errors++;
        $display("FAIL p64_result[%0d]: got %b/%h, want %b/%h", i, z64, res64, e[64], e[63:0]);
      end
      or64 = 1'b1;
      tick();
      or64 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_or();
    test_ops();
    test_backpressure();
    test_ignore();
    test_reset_mid();
    test_param8();
    test_param64();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, want completion");
    $fatal(1, "timeout");
  end
endmodule
